// File: rtl/row_scan_sequencer_pkg.sv
// Shared constants for the row scan sequencer: FSM state codes and row geometry.
package row_scan_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GAP   = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int ROWS  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

endpackage

// File: rtl/row_scan_sequencer_dwell_timer.sv
// Dwell counter for one row: counts enabled cycles, clear has priority,
// tc flags the last dwell cycle (cnt == DWELL-1).
module dwell_timer
    import row_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/row_scan_sequencer.sv
// Row scan sequencer: sweeps decoder rows 0..7 with a one-cycle dark gap
// between rows, samples sense on each row's last dwell cycle, publishes an 8-bit snapshot.
module row_scan_sequencer
    import row_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic       sense,
    output logic       d2,
    output logic       d1,
    output logic       d0,
    output logic       en,
    output logic [7:0] row_data,
    output logic       valid,
    output logic       busy
);

    logic [1:0]       state_q,    state_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [ROWS-2:0]  shadow_q,   shadow_d;
    logic [ROWS-1:0]  row_data_q, row_data_d;
    logic             tc;

    // Counter runs only while driving and restarts at every row boundary.
    dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
        .clk (clk),
        .rst (rst),
        .clr ((state_q != ST_DRIVE) || tc),
        .en  (state_q == ST_DRIVE),
        .tc  (tc)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        row_data_d = row_data_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (start) state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (tc) begin
                    if (idx_q == IDX_W'(ROWS - 1)) begin
                        // Last row goes straight into the snapshot, not the shadow.
                        row_data_d = {sense, shadow_q};
                        idx_d      = '0;
                        state_d    = ST_DONE;
                    end else begin
                        for (int i = 0; i < ROWS - 1; i++) begin
                            if (idx_q == IDX_W'(i)) shadow_d[i] = sense;
                        end
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_GAP;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = cont ? ST_GAP : ST_IDLE;
            end
        endcase
        // Abort discards the in-progress sweep; the last snapshot survives.
        if (stop) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            row_data_d = row_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            row_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            row_data_q <= row_data_d;
        end
    end

    assign {d2, d1, d0} = idx_q;
    assign en           = (state_q == ST_DRIVE);
    assign valid        = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign row_data     = row_data_q;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Bench for row_scan_sequencer: sweep timeline model derived from cycle arithmetic,
// sense driven from a per-row bit pattern as a keypad would return it.
module tb_row_scan_sequencer;

  localparam int D = 4;
  localparam int SWEEP = 8 * (D + 1);

  logic clk = 1'b0;
  logic rst, start, stop, cont, sense;
  logic d2, d1, d0, en, valid, busy;
  logic [7:0] row_data;
  logic [7:0] pat;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model: sweep position p (1..SWEEP = rows, SWEEP+1 = done)
  bit m_active;
  int m_p;
  logic [7:0] m_shadow;
  logic [7:0] m_row_data;

  always #5 clk = ~clk;

  assign sense = en & pat[{d2, d1, d0}];

  row_scan_sequencer #(.DWELL(D)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .sense(sense),
    .d2(d2), .d1(d1), .d0(d0), .en(en), .row_data(row_data), .valid(valid), .busy(busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock; update the model with the inputs sampled at this edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 0; m_p = 0; m_row_data = 8'h00;
    end else if (stop) begin
      m_active = 0; m_p = 0;
    end else if (!m_active) begin
      if (start) begin m_active = 1; m_p = 1; end
    end else if (m_p <= SWEEP) begin
      if ((m_p - 1) % (D + 1) == D) m_shadow[(m_p - 1) / (D + 1)] = pat[(m_p - 1) / (D + 1)];
      if (m_p == SWEEP) m_row_data = m_shadow;
      m_p++;
    end else begin
      if (cont) m_p = 1;
      else begin m_active = 0; m_p = 0; end
    end
    #1;
  endtask

  // {busy, en, sel[2:0], valid, row_data[7:0]} predicted for the current cycle
  function automatic logic [13:0] exp_vec();
    int r;
    if (!m_active) return {1'b0, 1'b0, 3'd0, 1'b0, m_row_data};
    if (m_p <= SWEEP) begin
      r = (m_p - 1) / (D + 1);
      return {1'b1, ((m_p - 1) % (D + 1)) != 0, 3'(r), 1'b0, m_row_data};
    end
    return {1'b1, 1'b0, 3'd0, 1'b1, m_row_data};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {busy, en, d2, d1, d0, valid, row_data};
  endfunction

  task automatic test_reset();
    rst = 1; start = 0; stop = 0; cont = 0; pat = 8'h00;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (obs_vec() !== 14'h0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 14'h0);
    end
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_sweep(input logic [7:0] p);
    int n_valid = 0;
    logic prev_en = 0;
    logic [2:0] prev_sel = 0;
    int gap_run = 0;
    pat = p; start = 1;
    step();
    start = 0;
    for (int i = 0; i < SWEEP + 6; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL sweep_%h cyc=%0d got=%h exp=%h", p, cyc, obs_vec(), exp_vec());
      end
      n_checks++;
      if (prev_en && en && ({d2, d1, d0} !== prev_sel)) begin
        n_fail++; $display("FAIL bbm_select cyc=%0d sel=%0d prev=%0d", cyc, {d2, d1, d0}, prev_sel);
      end
      if (busy && !en && !valid) gap_run++;
      if (en && gap_run != 0) begin
        n_checks++;
        if (gap_run != 1) begin
          n_fail++; $display("FAIL gap_len cyc=%0d got=%0d exp=1", cyc, gap_run);
        end
        gap_run = 0;
      end
      if (valid) n_valid++;
      prev_en = en; prev_sel = {d2, d1, d0};
    end
    n_checks++;
    if (n_valid != 1 || row_data !== p) begin
      n_fail++; $display("FAIL sweep_result valids=%0d exp=1 row_data=%h exp=%h", n_valid, row_data, p);
    end
  endtask

  task automatic test_random_start_noise();
    for (int s = 0; s < 3; s++) begin
      pat = 8'($urandom);
      start = 1;
      for (int i = 0; i < SWEEP + 4; i++) begin
        step();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL start_noise cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
        start = ($urandom_range(0, 3) == 0);
      end
      start = 0;
      for (int i = 0; i < SWEEP + 4; i++) begin
        step();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL start_noise_tail cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_continuous();
    int v_cyc[$];
    logic [7:0] v_data[$];
    cont = 1; pat = 8'hA5; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3 * SWEEP && v_cyc.size() < 2; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL continuous cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (valid) begin
        v_cyc.push_back(cyc); v_data.push_back(row_data);
        pat = 8'h3C;
        if (v_cyc.size() == 2) cont = 0;
      end
    end
    n_checks++;
    if (v_cyc.size() != 2) begin
      n_fail++; $display("FAIL cont_valid_count got=%0d exp=2", v_cyc.size());
    end else begin
      n_checks++;
      if (v_cyc[1] - v_cyc[0] != SWEEP + 1) begin
        n_fail++; $display("FAIL cont_period got=%0d exp=%0d", v_cyc[1] - v_cyc[0], SWEEP + 1);
      end
      n_checks++;
      if (v_data[0] !== 8'hA5 || v_data[1] !== 8'h3C) begin
        n_fail++; $display("FAIL cont_data got=%h,%h exp=a5,3c", v_data[0], v_data[1]);
      end
    end
    cont = 0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_stop();
    test_single_sweep(8'hA5);
    pat = 8'($urandom); start = 1;
    step();
    start = 0;
    for (int i = 0; i < 19; i++) step();
    stop = 1; start = 1;
    step();
    stop = 0; start = 0;
    n_checks++;
    if (busy !== 1'b0 || en !== 1'b0 || valid !== 1'b0 || row_data !== 8'hA5 || {d2, d1, d0} !== 3'd0) begin
      n_fail++; $display("FAIL stop_abort got=%h exp busy=0 en=0 sel=0 valid=0 row_data=a5", obs_vec());
    end
    for (int i = 0; i < SWEEP + 4; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stop_after cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_wins busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    pat = 8'($urandom); start = 1;
    step();
    start = 0;
    for (int i = 0; i < 14; i++) step();
    rst = 1;
    step();
    rst = 0;
    n_checks++;
    if (obs_vec() !== 14'h0) begin
      n_fail++; $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 14'h0);
    end
    step();
    test_single_sweep(8'($urandom));
  endtask

  initial begin
    test_reset();
    test_single_sweep(8'h20);
    test_single_sweep(8'($urandom));
    test_random_start_noise();
    test_continuous();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
